// File: rtl/mod_n_counter_fsm.sv
// Modulo-N counter FSM: up-wrap, down-wrap, ping-pong and up-saturate counting
// over 0..MAX, with enable, clamped synchronous load, terminal strobe and toggle output.
module mod_n_counter_fsm #(
    parameter int WIDTH = 3,
    parameter int MAX   = 7
) (
    input  logic             clk,
    input  logic             re,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc,
    output logic             Salida
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_SAT  = 2'b11
    } mode_t;

    typedef enum logic {
        ST_DOWN = 1'b0,
        ST_UP   = 1'b1
    } state_t;

    logic [WIDTH-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic             salida_q, salida_d;

    mode_t mode_s;
    logic  at_max;
    logic  at_zero;
    logic  over_max;
    logic  at_top;
    logic  terminal;

    assign mode_s   = mode_t'(mode);
    assign at_max   = (count_q == MAX_V);
    assign at_zero  = (count_q == '0);
    assign over_max = (count_q > MAX_V);
    assign at_top   = at_max | over_max;

    // A count above MAX can only appear after a MAX change; treat it as terminal everywhere.
    always_comb begin
        terminal = over_max;
        case (mode_s)
            MODE_UP:   terminal = at_top;
            MODE_SAT:  terminal = at_top;
            MODE_DOWN: terminal = at_zero | over_max;
            MODE_PING: terminal = over_max
                                | ((state_q == ST_UP)   & at_max)
                                | ((state_q == ST_DOWN) & at_zero);
            default:   terminal = over_max;
        endcase
    end

    assign tc = en & ~load & terminal;

    always_comb begin
        count_d  = count_q;
        state_d  = state_q;
        salida_d = salida_q ^ tc;
        if (load) begin
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            case (mode_s)
                MODE_UP: begin
                    count_d = at_top ? '0 : count_q + ONE_V;
                    state_d = ST_UP;
                end
                MODE_DOWN: begin
                    count_d = (at_zero | over_max) ? MAX_V : count_q - ONE_V;
                    state_d = ST_DOWN;
                end
                MODE_SAT: begin
                    count_d = at_top ? MAX_V : count_q + ONE_V;
                    state_d = ST_UP;
                end
                MODE_PING: begin
                    // With MAX of zero there is nowhere to bounce, so count and direction freeze.
                    if (MAX == 0) begin
                        count_d = '0;
                    end else if (over_max) begin
                        count_d = MAX_V - ONE_V;
                        state_d = ST_DOWN;
                    end else if (state_q == ST_UP) begin
                        if (at_max) begin
                            count_d = MAX_V - ONE_V;
                            state_d = ST_DOWN;
                        end else begin
                            count_d = count_q + ONE_V;
                        end
                    end else begin
                        if (at_zero) begin
                            count_d = ONE_V;
                            state_d = ST_UP;
                        end else begin
                            count_d = count_q - ONE_V;
                        end
                    end
                end
                default: begin
                    count_d = count_q;
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge re) begin
        if (!re) begin
            count_q  <= '0;
            state_q  <= ST_UP;
            salida_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            state_q  <= state_d;
            salida_q <= salida_d;
        end
    end

    assign count  = count_q;
    assign dir    = (state_q == ST_UP);
    assign Salida = salida_q;

endmodule
